// File: rtl/outc_credit_link.sv
// Router output-channel stage: registers crossbar flits onto the link, tracks per-VC credits
// and packet locks for the neighbour's VC FIFOs. Optional flit counter under OUTC_STAT_EN.
module outc_credit_link #(
  parameter int unsigned ROUTERID      = 0,
  parameter int unsigned PCHID         = 0,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned VCH_WIDTH     = 4,
  parameter int unsigned VCH_WIDTH_NUM = 2,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TYPE_MSB      = 31,
  parameter int unsigned TYPE_LSB      = 29
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ivalid,
  input  logic [VCH_WIDTH_NUM-1:0] ivch,
  input  logic [DATA_WIDTH-1:0]    idata,
  input  logic [VCH_WIDTH-1:0]     iack,
  output logic                     ovalid,
  output logic [VCH_WIDTH_NUM-1:0] ovch,
  output logic [DATA_WIDTH-1:0]    odata,
  output logic [VCH_WIDTH-1:0]     ordy,
  output logic [VCH_WIDTH-1:0]     olck,
  output logic                     err,
  output logic [15:0]              flit_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = TYPE_MSB - TYPE_LSB + 1;

  localparam logic [TW-1:0] TYPE_NONE     = TW'(0);
  localparam logic [TW-1:0] TYPE_HEAD     = TW'(1);
  localparam logic [TW-1:0] TYPE_BODY     = TW'(2);
  localparam logic [TW-1:0] TYPE_TAIL     = TW'(3);
  localparam logic [CW-1:0] CREDIT_FULL   = CW'(DEPTH);

  typedef enum logic {LkFree, LkBusy} lock_e;

  logic [VCH_WIDTH-1:0][CW-1:0] credit_q, credit_d;
  lock_e [VCH_WIDTH-1:0]        lock_q, lock_d;
  logic                         ovalid_q;
  logic [VCH_WIDTH_NUM-1:0]     ovch_q;
  logic [DATA_WIDTH-1:0]        odata_q;
  logic [VCH_WIDTH-1:0]         ordy_q;
  logic                         err_q;

  logic [TW-1:0]        flit_type;
  logic [CW-1:0]        sel_credit;
  lock_e                sel_lock;
  logic                 accept;
  logic                 drop_err;
  logic                 lock_err;
  logic [VCH_WIDTH-1:0] ack_err;
  logic                 err_event;
  logic                 dec;

  always_comb begin
    flit_type  = idata[TYPE_MSB:TYPE_LSB];
    sel_credit = credit_q[ivch];
    sel_lock   = lock_q[ivch];
    accept     = ivalid && (sel_credit != '0) && (flit_type != TYPE_NONE);
    drop_err   = ivalid && (sel_credit == '0);

    // Spend and return on the same VC in one cycle cancel out, even at full credit.
    credit_d = credit_q;
    ack_err  = '0;
    dec      = 1'b0;
    for (int v = 0; v < VCH_WIDTH; v++) begin
      dec = accept && (ivch == VCH_WIDTH_NUM'(v));
      case ({iack[v], dec})
        2'b10: begin
          if (credit_q[v] == CREDIT_FULL) ack_err[v] = 1'b1;
          else                            credit_d[v] = credit_q[v] + CW'(1);
        end
        2'b01:   credit_d[v] = credit_q[v] - CW'(1);
        default: credit_d[v] = credit_q[v];
      endcase
    end

    lock_d   = lock_q;
    lock_err = 1'b0;
    if (accept) begin
      case (flit_type)
        TYPE_HEAD: begin
          if (sel_lock == LkBusy) lock_err = 1'b1;
          else                    lock_d[ivch] = LkBusy;
        end
        TYPE_TAIL: begin
          if (sel_lock == LkBusy) lock_d[ivch] = LkFree;
          else                    lock_err = 1'b1;
        end
        TYPE_BODY: begin
          if (sel_lock == LkFree) lock_err = 1'b1;
        end
        // Single-flit packets must not interleave into an open packet.
        default: begin
          if (sel_lock == LkBusy) lock_err = 1'b1;
        end
      endcase
    end

    err_event = drop_err || (|ack_err) || lock_err;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VCH_WIDTH; v++) begin
        credit_q[v] <= CREDIT_FULL;
        lock_q[v]   <= LkFree;
      end
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
      odata_q  <= '0;
      ordy_q   <= '1;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      lock_q   <= lock_d;
      ovalid_q <= accept;
      if (accept) ovch_q <= ivch;
      odata_q  <= accept ? idata : '0;
      for (int v = 0; v < VCH_WIDTH; v++) begin
        ordy_q[v] <= (credit_d[v] != '0);
      end
      err_q    <= err_q || err_event;
    end
  end

  always_comb begin
    for (int v = 0; v < VCH_WIDTH; v++) begin
      olck[v] = (lock_q[v] == LkBusy);
    end
  end

  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;
  assign odata  = odata_q;
  assign ordy   = ordy_q;
  assign err    = err_q;

`ifdef OUTC_STAT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ovalid_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign flit_cnt = cnt_q;
`else
  assign flit_cnt = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && err_event) begin
      $display("outc_credit_link r%0d p%0d: protocol error (drop=%0b ack=%b lock=%0b) at %0t",
               ROUTERID, PCHID, drop_err, ack_err, lock_err, $time);
    end
  end
`endif

endmodule

// File: tb/tb_outc_credit_link.sv
// Directed and randomized bench for outc_credit_link against a credit/lock reference model.
module tb_outc_credit_link;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ivalid;
  logic [1:0]  ivch;
  logic [31:0] idata;
  logic [3:0]  iack;
  logic        ovalid;
  logic [1:0]  ovch;
  logic [31:0] odata;
  logic [3:0]  ordy;
  logic [3:0]  olck;
  logic        err;
  logic [15:0] flit_cnt;

  int checks = 0;
  int errors = 0;

  int          m_cred [4];
  bit          m_busy [4];
  bit          m_err;
  bit          m_ov;
  logic [1:0]  m_ovch;
  logic [31:0] m_od;
  int          m_cnt;

  outc_credit_link #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .ivalid   (ivalid),
    .ivch     (ivch),
    .idata    (idata),
    .iack     (iack),
    .ovalid   (ovalid),
    .ovch     (ovch),
    .odata    (odata),
    .ordy     (ordy),
    .olck     (olck),
    .err      (err),
    .flit_cnt (flit_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] flit(input int t, input logic [28:0] payload);
    logic [31:0] f;
    f = {t[2:0], payload};
    return f;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_cred[v] = DEPTH;
      m_busy[v] = 1'b0;
    end
    m_err = 1'b0; m_ov = 1'b0; m_ovch = 2'd0; m_od = '0; m_cnt = 0;
  endtask

  task automatic model_step(input bit iv, input int vc, input logic [31:0] d,
                            input logic [3:0] ack);
    int t;
    int newc;
    bit acc;
    t = int'(d[31:29]);
`ifdef OUTC_STAT_EN
    if (m_ov) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
`endif
    acc = iv && (m_cred[vc] > 0) && (t != 0);
    if (iv && m_cred[vc] == 0) m_err = 1'b1;
    for (int v = 0; v < 4; v++) begin
      newc = m_cred[v] + int'(ack[v]) - ((acc && vc == v) ? 1 : 0);
      if (newc > DEPTH) begin
        newc  = DEPTH;
        m_err = 1'b1;
      end
      m_cred[v] = newc;
    end
    if (acc) begin
      if (t == 1) begin
        if (m_busy[vc]) m_err = 1'b1; else m_busy[vc] = 1'b1;
      end else if (t == 3) begin
        if (m_busy[vc]) m_busy[vc] = 1'b0; else m_err = 1'b1;
      end else if (t == 2) begin
        if (!m_busy[vc]) m_err = 1'b1;
      end else begin
        if (m_busy[vc]) m_err = 1'b1;
      end
      m_ov = 1'b1; m_ovch = 2'(vc); m_od = d;
    end else begin
      m_ov = 1'b0; m_od = '0;
    end
  endtask

  task automatic chk(input string tag, input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s %s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] e_rdy;
    logic [3:0] e_lck;
    for (int v = 0; v < 4; v++) begin
      e_rdy[v] = (m_cred[v] != 0);
      e_lck[v] = m_busy[v];
    end
    chk(tag, "ovalid", 32'(ovalid), 32'(m_ov));
    chk(tag, "ovch", 32'(ovch), 32'(m_ovch));
    chk(tag, "odata", odata, m_od);
    chk(tag, "ordy", 32'(ordy), 32'(e_rdy));
    chk(tag, "olck", 32'(olck), 32'(e_lck));
    chk(tag, "err", 32'(err), 32'(m_err));
    chk(tag, "flit_cnt", 32'(flit_cnt), 32'(m_cnt));
  endtask

  task automatic step(input bit iv, input int vc, input logic [31:0] d, input logic [3:0] ack,
                      input string tag);
    ivalid = iv; ivch = 2'(vc); idata = d; iack = ack;
    model_step(iv, vc, d, ack);
    @(posedge clk);
    #1;
    ivalid = 1'b0; iack = '0; idata = '0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] x;
    reset = 1'b1; ivalid = 1'b0; ivch = '0; idata = '0; iack = '0;
    #3;
    do_reset("reset");

    // Head on VC2
    x = flit(1, 29'h0ABC123);
    step(1, 2, x, 4'b0000, "head_vc2");
    chk("head_vc2", "credit2_rdy", 32'(ordy), 32'hF);
    chk("head_vc2", "olck_0100", 32'(olck), 32'h4);
    step(0, 0, '0, 4'b0000, "idle_after_head");

    // Exhaust VC1 credits, then overrun
    do_reset("reset_vc1");
    step(1, 1, flit(1, 29'h11), 4'b0, "vc1_head");
    step(1, 1, flit(2, 29'h12), 4'b0, "vc1_body1");
    step(1, 1, flit(2, 29'h13), 4'b0, "vc1_body2");
    step(1, 1, flit(3, 29'h14), 4'b0, "vc1_tail");
    chk("vc1_tail", "ordy1_low", 32'(ordy[1]), 32'd0);
    step(1, 1, flit(1, 29'h15), 4'b0, "vc1_overrun");
    chk("vc1_overrun", "err_set", 32'(err), 32'd1);

    // Same-cycle spend and return at credit 1
    do_reset("reset_vc0");
    step(1, 0, flit(1, 29'h21), 4'b0, "vc0_head");
    step(1, 0, flit(2, 29'h22), 4'b0, "vc0_body1");
    step(1, 0, flit(2, 29'h23), 4'b0, "vc0_body2");
    step(1, 0, flit(2, 29'h24), 4'b0001, "vc0_body_ack");
    step(1, 0, flit(3, 29'h25), 4'b0, "vc0_tail");

    // Ack overflow straight after reset
    do_reset("reset_ack");
    step(0, 0, '0, 4'b1111, "ack_overflow");

    // Single-flit packet and body on free VC
    do_reset("reset_ht");
    step(1, 3, flit(4, 29'h31), 4'b0, "vc3_headtail");
    step(1, 0, flit(2, 29'h32), 4'b0, "vc0_free_body");

    // Reset mid-packet while a flit is on the link
    do_reset("reset_mid");
    step(1, 2, flit(1, 29'h41), 4'b0, "vc2_head");
    step(1, 2, flit(2, 29'h42), 4'b0, "vc2_body");
    do_reset("reset_inflight");

    // Ten flits then the counter
    for (int i = 0; i < 10; i++) begin
      int vc;
      vc = int'($urandom_range(0, 3));
      step(1, vc, flit(4, 29'($urandom)), 4'b0001 << vc, "cnt_flit");
    end
    step(0, 0, '0, 4'b0, "cnt_idle");
`ifdef OUTC_STAT_EN
    chk("cnt_ten", "flit_cnt", 32'(flit_cnt), 32'd10);
`else
    chk("cnt_ten", "flit_cnt", 32'(flit_cnt), 32'd0);
`endif

    // Randomized traffic
    for (int blk = 0; blk < 3; blk++) begin
      do_reset("reset_rand");
      for (int i = 0; i < 120; i++) begin
        bit iv;
        int vc;
        int t;
        logic [3:0] ack;
        iv  = ($urandom_range(0, 3) != 0);
        vc  = int'($urandom_range(0, 3));
        t   = int'($urandom_range(0, 7));
        ack = 4'($urandom & $urandom);
        step(iv, vc, flit(t, 29'($urandom)), ack, "random");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/outc_credit_link.md
Name: outc_credit_link

Overview:
- Output-channel stage of a router: sits directly downstream of the crossbar and upstream of the neighbour router's input channel on one physical link.
- Registers crossbar flits onto the link and tracks per-VC credits for the neighbour's VC FIFOs; credits are returned by the neighbour's per-VC ack.
- Tracks per-VC packet lock and exports ready/lock vectors back to every input channel of its own router (irdy_N / ilck_N there).

Parameters:
ROUTERID, 0, router index (used only in the error trace message)
PCHID, 0, physical channel index of this output
DEPTH, 4, neighbour VC FIFO depth = initial credits per VC (2..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ivalid  in  1  flit valid from crossbar
ivch  in  VCH_WIDTH_NUM  target VC on the link
idata  in  DATA_WIDTH  flit from crossbar
iack  in  VCH_WIDTH  per-VC credit return from neighbour (1 credit per set bit per cycle)
ovalid  out  1  link flit valid
ovch  out  VCH_WIDTH_NUM  link VC id
odata  out  DATA_WIDTH  link flit
ordy  out  VCH_WIDTH  per-VC "at least one credit" to input channels
olck  out  VCH_WIDTH  per-VC "VC owned by an in-flight packet"
err  out  1  sticky protocol-error flag
flit_cnt  out  16  sent-flit counter (see Optional Feature)

Behaviour:
- Reset (reset==0, async): credit[v]=DEPTH, lock[v]=0, ovalid=0, ovch=0, odata=0, ordy=all 1, olck=0, err=0, flit_cnt=0.
- Flit type = idata[TYPE_MSB:TYPE_LSB]. Accept = ivalid && credit[ivch]!=0 && type!=TYPE_NONE.
- Link output: 1-cycle latency; on accept, next cycle ovalid=1, ovch=ivch, odata=idata. Otherwise ovalid=0, odata=0, ovch holds.
- Credit counter per VC, width ceil(log2(DEPTH+1)):
  - accept only: -1
  - iack only: +1
  - both same cycle: unchanged
  - iack at credit==DEPTH: saturate at DEPTH, set err
  - ivalid at credit==0: flit dropped (no ovalid), set err
- ordy[v] is registered: ordy[v] = (credit_next[v] != 0). The cycle a VC spends its last credit, ordy drops the following cycle. Input channels must not send on a VC whose ordy was 0 in the previous cycle.
- Lock FSM per VC, states FREE/BUSY:
  - FREE -> BUSY on accepted TYPE_HEAD.
  - BUSY -> FREE on accepted TYPE_TAIL.
  - TYPE_HEADTAIL, TYPE_TEST, TYPE_ACK and TYPE_ACK_BACK are single-flit: FREE stays FREE.
  - Body/tail arriving in FREE, or head-type arriving in BUSY: flit still forwarded, state unchanged, err set.
  - olck[v] = (state[v]==BUSY), registered.
- Only one flit per cycle (crossbar guarantees). iack may carry multiple bits set in one cycle; each VC is updated independently.
- err is sticky until reset. Simulation-only: $display with ROUTERID/PCHID on each error event.
- Reset asserted mid-packet: all locks free, credits full, the in-flight output flit is discarded.

Optional Feature:
- Macro OUTC_STAT_EN.
- Defined: flit_cnt increments on every ovalid cycle, saturating at 16'hFFFF.
- Undefined: counter logic is absent and flit_cnt is tied to 0. The port remains, so the interface is unchanged.

Test Plan:
- Reset, then head flit (TYPE_HEAD) on ivch=2 with idata=X -> next cycle ovalid=1, ovch=2, odata=X; credit[2]=3; olck=4'b0100; ordy=4'b1111.
- 4 flits on VC1 (head, body, body, tail), no iack -> after the 4th, ordy[1]=0 and olck[1]=0; a 5th flit on VC1 is dropped, err=1, ovalid stays 0.
- VC0 at credit 1: flit accepted together with iack[0]=1 in the same cycle -> credit stays 1, ordy[0] stays 1.
- iack=4'b1111 right after reset -> credits remain 4, err=1.
- TYPE_HEADTAIL on VC3 -> forwarded, olck[3] never rises. Body flit on free VC0 -> forwarded, err=1.
- Mid-packet on VC2 (olck[2]=1, credit=2), assert reset -> olck=0, ordy=4'b1111, ovalid=0. With OUTC_STAT_EN, 10 sent flits -> flit_cnt=10.
